darkbus_uart_master: RTL and testbench

//  Debug/boot bus initiator: turns a host byte stream (from a UART receiver) into darkriscv-style
//  32-bit data-bus read/write cycles and streams replies back to a UART transmitter. It is the

---
 rtl/darkbus_uart_master_pkg.sv | 21 ++
 rtl/darkbus_uart_txseq.sv | 32 +++
 rtl/darkbus_uart_master.sv | 148 ++++++++++++++
 tb/tb_darkbus_uart_master.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/darkbus_uart_master_pkg.sv
// rtl/darkbus_uart_master_pkg.sv - opcodes, reply bytes and FSM states for the UART bus master
package darkbus_uart_master_pkg;

    localparam logic [7:0] OP_W  = 8'h57;
    localparam logic [7:0] OP_R  = 8'h52;
    localparam logic [7:0] OP_H  = 8'h48;
    localparam logic [7:0] OP_G  = 8'h47;

    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_E = 8'h45;
    localparam logic [7:0] RSP_T = 8'h54;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/darkbus_uart_txseq.sv
// rtl/darkbus_uart_txseq.sv - reply byte sequencer: 4-byte shift register, MSB byte first
module darkbus_uart_txseq (
    input  logic        CLK,
    input  logic        RESN,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_cnt,
    input  logic        advance,
    output logic [7:0]  TXDATA,
    output logic        last
);

    logic [31:0] sreg;
    logic [2:0]  cnt;

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            sreg <= 32'h0;
            cnt  <= 3'd0;
        end else if (load) begin
            sreg <= load_data;
            cnt  <= load_cnt;
        end else if (advance) begin
            sreg <= {sreg[23:0], 8'h00};
            cnt  <= cnt - 3'd1;
        end
    end

    assign TXDATA = sreg[31:24];
    assign last   = (cnt == 3'd1);

endmodule

// File: rtl/darkbus_uart_master.sv
// rtl/darkbus_uart_master.sv - host byte stream to 32-bit darkriscv bus cycles, replies to UART TX
module darkbus_uart_master
    import darkbus_uart_master_pkg::*;
#(
    parameter int TOUT     = 255,
    parameter bit HOLD_RST = 1'b1
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic [7:0]  RXDATA,
    input  logic        RXVLD,
    output logic [7:0]  TXDATA,
    output logic        TXVLD,
    input  logic        TXRDY,
    output logic [31:0] DADDR,
    output logic [31:0] DATAO,
    output logic [3:0]  BE,
    output logic        WR,
    output logic        RD,
    input  logic [31:0] DATAI,
    input  logic        ACK,
    output logic        HOLD,
    output logic        BUSY
);

    state_t      state, state_nxt;
    logic        is_wr;
    logic [1:0]  cnt;
    logic [7:0]  tcnt;
    logic        tout_hit;
    logic        tx_load;
    logic [31:0] tx_load_data;
    logic [2:0]  tx_load_cnt;
    logic        tx_last;

    assign tout_hit = (tcnt == 8'(TOUT - 1));
    assign TXVLD    = (state == ST_RESP);
    assign BUSY     = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Reply contents are decided at the transition into RESP and loaded into the sequencer.
    always_comb begin
        state_nxt    = state;
        tx_load      = 1'b0;
        tx_load_data = {RSP_K, 24'h0};
        tx_load_cnt  = 3'd1;
        case (state)
            ST_IDLE: if (RXVLD) begin
                case (RXDATA)
                    OP_W, OP_R: state_nxt = ST_ADDR;
                    OP_H, OP_G: begin
                        state_nxt = ST_RESP;
                        tx_load   = 1'b1;
                    end
                    default: begin
                        state_nxt    = ST_RESP;
                        tx_load      = 1'b1;
                        tx_load_data = {RSP_E, 24'h0};
                    end
                endcase
            end
            ST_ADDR: if (RXVLD && cnt == 2'd3) state_nxt = is_wr ? ST_DATA : ST_BUS;
            ST_DATA: if (RXVLD && cnt == 2'd3) state_nxt = ST_BUS;
            ST_BUS: begin
                if (ACK) begin
                    state_nxt = ST_RESP;
                    tx_load   = 1'b1;
                    if (!is_wr) begin
                        tx_load_data = DATAI;
                        tx_load_cnt  = 3'd4;
                    end
                end else if (tout_hit) begin
                    state_nxt    = ST_RESP;
                    tx_load      = 1'b1;
                    tx_load_data = {RSP_T, 24'h0};
                end
            end
            ST_RESP: if (TXRDY && tx_last) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            DADDR <= 32'h0;
            DATAO <= 32'h0;
            BE    <= 4'h0;
            WR    <= 1'b0;
            RD    <= 1'b0;
            HOLD  <= HOLD_RST;
            is_wr <= 1'b0;
            cnt   <= 2'd0;
            tcnt  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: if (RXVLD) begin
                    is_wr <= (RXDATA == OP_W);
                    cnt   <= 2'd0;
                    if (RXDATA == OP_H) HOLD <= 1'b1;
                    if (RXDATA == OP_G) HOLD <= 1'b0;
                end
                ST_ADDR: if (RXVLD) begin
                    DADDR <= {DADDR[23:0], RXDATA};
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3 && !is_wr) begin
                        RD   <= 1'b1;
                        BE   <= 4'hF;
                        tcnt <= 8'd0;
                    end
                end
                ST_DATA: if (RXVLD) begin
                    DATAO <= {DATAO[23:0], RXDATA};
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        WR   <= 1'b1;
                        BE   <= 4'hF;
                        tcnt <= 8'd0;
                    end
                end
                ST_BUS: begin
                    tcnt <= tcnt + 8'd1;
                    if (ACK || tout_hit) begin
                        WR <= 1'b0;
                        RD <= 1'b0;
                        BE <= 4'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    darkbus_uart_txseq u_txseq (
        .CLK       (CLK),
        .RESN      (RESN),
        .load      (tx_load),
        .load_data (tx_load_data),
        .load_cnt  (tx_load_cnt),
        .advance   (TXVLD && TXRDY),
        .TXDATA    (TXDATA),
        .last      (tx_last)
    );

endmodule

// File: tb/tb_darkbus_uart_master.sv
// tb/tb_darkbus_uart_master.sv - self-checking bench for darkbus_uart_master
module tb_darkbus_uart_master;
    import darkbus_uart_master_pkg::*;

    localparam int TOUT = 255;

    logic        CLK = 1'b0;
    logic        RESN = 1'b0;
    logic [7:0]  RXDATA = 8'h00;
    logic        RXVLD = 1'b0;
    logic [7:0]  TXDATA;
    logic        TXVLD;
    logic        TXRDY = 1'b1;
    logic [31:0] DADDR, DATAO;
    logic [31:0] DATAI = 32'h0;
    logic [3:0]  BE;
    logic        WR, RD;
    logic        ACK = 1'b0;
    logic        HOLD, BUSY;

    always #5 CLK = ~CLK;

    darkbus_uart_master #(.TOUT(TOUT), .HOLD_RST(1'b1)) dut (
        .CLK(CLK), .RESN(RESN), .RXDATA(RXDATA), .RXVLD(RXVLD),
        .TXDATA(TXDATA), .TXVLD(TXVLD), .TXRDY(TXRDY),
        .DADDR(DADDR), .DATAO(DATAO), .BE(BE), .WR(WR), .RD(RD),
        .DATAI(DATAI), .ACK(ACK), .HOLD(HOLD), .BUSY(BUSY)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } bexp_t;

    bexp_t       bexp[$];
    logic [7:0]  txexp[$];
    logic [7:0]  txlog[$];
    int          errors = 0;
    int          checks = 0;
    bit          model_hold = 1'b1;
    int          ack_after = 0;
    int          stall_left = 0;
    int          req_cnt = 0;
    int          run = 0;
    int          last_run_len = 0;
    bit          have_cur = 1'b0;
    bexp_t       cur;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_txdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] last4();
        int n = txlog.size();
        if (n < 4) return 32'hxxxxxxxx;
        return {txlog[n-4], txlog[n-3], txlog[n-2], txlog[n-1]};
    endfunction

    // Bus responder: ACK in the ack_after-th cycle of a request (0 = never).
    always @(posedge CLK) begin
        #1;
        if (WR || RD) begin
            req_cnt++;
            ACK = (req_cnt == ack_after);
        end else begin
            req_cnt = 0;
            ACK = 1'b0;
        end
    end

    always @(posedge CLK) begin
        #1;
        if (stall_left > 0 && TXVLD) begin
            TXRDY = 1'b0;
            stall_left--;
        end else begin
            TXRDY = 1'b1;
        end
    end

    // Compare process: every cycle against the bus/reply expectation queues.
    always @(negedge CLK) begin
        if (!RESN) begin
            run = 0;
            have_cur = 1'b0;
            bexp.delete();
            txexp.delete();
            prev_stall = 1'b0;
        end else begin
            chk("wr_rd_excl", {31'h0, WR & RD}, 32'h0);
            chk("be", {28'h0, BE}, {28'h0, {4{WR | RD}}});
            chk("hold", {31'h0, HOLD}, {31'h0, model_hold});
            if (WR || RD || TXVLD) chk("busy", {31'h0, BUSY}, 32'h1);
            if (prev_stall) begin
                chk("txvld_held", {31'h0, TXVLD}, 32'h1);
                chk("txdata_stable", {24'h0, TXDATA}, {24'h0, prev_txdata});
            end
            prev_stall  = TXVLD && !TXRDY;
            prev_txdata = TXDATA;
            if (TXVLD && TXRDY) begin
                txlog.push_back(TXDATA);
                if (txexp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %h expected none", TXDATA);
                end else begin
                    chk("txbyte", {24'h0, TXDATA}, {24'h0, txexp.pop_front()});
                end
            end
            if (WR || RD) begin
                if (run == 0) begin
                    if (bexp.size() == 0) begin
                        checks++;
                        errors++;
                        have_cur = 1'b0;
                        $display("FAIL unexpected_bus: got WR=%b RD=%b expected idle", WR, RD);
                    end else begin
                        cur = bexp.pop_front();
                        have_cur = 1'b1;
                        chk("bus_wr", {31'h0, WR}, {31'h0, cur.wr});
                        chk("bus_rd", {31'h0, RD}, {31'h0, !cur.wr});
                    end
                end
                if (have_cur) begin
                    chk("daddr", DADDR, cur.addr);
                    if (cur.wr) chk("datao", DATAO, cur.data);
                end
                run++;
            end else if (run > 0) begin
                if (have_cur) chk("req_len", run, cur.len);
                last_run_len = run;
                run = 0;
                have_cur = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RXDATA = b;
        RXVLD  = 1'b1;
        @(posedge CLK); #1;
        RXVLD  = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input int ackn, input logic [31:0] rdata);
        bexp_t e;
        int budget;
        bit is_bus;
        is_bus = (op == OP_W) || (op == OP_R);
        ack_after = ackn;
        DATAI = rdata;
        if (is_bus) begin
            e.wr = (op == OP_W);
            e.addr = addr;
            e.data = data;
            e.len = (ackn == 0) ? TOUT : ackn;
            bexp.push_back(e);
            if (ackn == 0) txexp.push_back(RSP_T);
            else if (op == OP_W) txexp.push_back(RSP_K);
            else for (int i = 3; i >= 0; i--) txexp.push_back(rdata[8*i +: 8]);
        end else if (op == OP_H || op == OP_G) begin
            txexp.push_back(RSP_K);
        end else begin
            txexp.push_back(RSP_E);
        end
        send_byte(op);
        if (op == OP_H) model_hold = 1'b1;
        if (op == OP_G) model_hold = 1'b0;
        if (is_bus) begin
            for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
            if (op == OP_W) for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
        end
        budget = 0;
        while (!(txexp.size() == 0 && !BUSY) && budget < 2000) begin
            @(posedge CLK); #1;
            budget++;
        end
        if (budget >= 2000) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout: got pending=%0d busy=%b expected 0 0", txexp.size(), BUSY);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bexp_t e;
        #12;
        chk("rst_hold", {31'h0, HOLD}, 32'h1);
        chk("rst_txvld", {31'h0, TXVLD}, 32'h0);
        chk("rst_txdata", {24'h0, TXDATA}, 32'h0);
        chk("rst_daddr", DADDR, 32'h0);
        chk("rst_datao", DATAO, 32'h0);
        chk("rst_be_wr_rd", {28'h0, BE, WR, RD, BUSY}, 32'h0);
        @(posedge CLK); #1;
        RESN = 1'b1;

        do_cmd(OP_G, 32'h0, 32'h0, 0, 32'h0);
        chk("g_hold_low", {31'h0, HOLD}, 32'h0);
        chk("g_reply", {24'h0, txlog[txlog.size()-1]}, 32'h4B);

        do_cmd(OP_W, 32'h0000_0100, 32'hDEAD_BEEF, 3, 32'h0);
        chk("w_len3", last_run_len, 32'd3);
        chk("w_reply", {24'h0, txlog[txlog.size()-1]}, 32'h4B);

        do_cmd(OP_R, 32'h8000_0008, 32'h0, 1, 32'h1234_5678);
        chk("r_len1", last_run_len, 32'd1);
        chk("r_bytes", last4(), 32'h1234_5678);

        do_cmd(OP_R, 32'h0000_0040, 32'h0, 0, 32'h0);
        chk("tout_len", last_run_len, 32'd255);
        chk("tout_reply", {24'h0, txlog[txlog.size()-1]}, 32'h54);
        do_cmd(OP_H, 32'h0, 32'h0, 0, 32'h0);
        chk("h_after_tout", {31'h0, HOLD}, 32'h1);

        do_cmd(8'h3F, 32'h0, 32'h0, 0, 32'h0);
        chk("bad_op_reply", {24'h0, txlog[txlog.size()-1]}, 32'h45);
        stall_left = 10;
        do_cmd(OP_R, 32'h0000_0200, 32'h0, 2, 32'hA1B2_C3D4);
        chk("stall_bytes", last4(), 32'hA1B2_C3D4);

        ack_after = 0;
        e.wr = 1'b1; e.addr = 32'h0000_0300; e.data = 32'h5555_AAAA; e.len = TOUT;
        bexp.push_back(e);
        txexp.push_back(RSP_T);
        send_byte(OP_W);
        for (int i = 3; i >= 0; i--) send_byte(e.addr[8*i +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(e.data[8*i +: 8]);
        repeat (3) @(posedge CLK);
        #1;
        chk("mid_wr_high", {31'h0, WR}, 32'h1);
        RESN = 1'b0;
        #1;
        chk("mid_wr_drop", {31'h0, WR}, 32'h0);
        chk("mid_reset_outs", {28'h0, BE, TXVLD, BUSY, HOLD}, 32'h1);
        chk("mid_reset_daddr", DADDR, 32'h0);
        model_hold = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESN = 1'b1;
        do_cmd(OP_R, 32'h0000_0010, 32'h0, 2, 32'hCAFE_F00D);
        chk("post_reset_read", last4(), 32'hCAFE_F00D);

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
